// File: rtl/operand_fwd_scoreboard.sv
// rtl/operand_fwd_scoreboard.sv - decode operand forwarding and pending-writer hazard scoreboard
module operand_fwd_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 3,
  parameter int CW   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_valid,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD*DW-1:0]   rf_rdata,
  input  logic [NFWD-1:0]     fwd_we,
  input  logic [NFWD*AW-1:0]  fwd_dest,
  input  logic [NFWD-1:0]     fwd_rdy,
  input  logic [NFWD*DW-1:0]  fwd_data,
  input  logic                iss_we,
  input  logic [AW-1:0]       iss_dest,
  input  logic                iss_fire,
  input  logic                ret_fire,
  input  logic [AW-1:0]       ret_dest,
  input  logic                flush,
  output logic [NRD*DW-1:0]   opnd_data,
  output logic                stall,
  output logic                sb_full,
  output logic                sb_err,
  output logic [31:0]         stall_cnt
);

  localparam logic [CW-1:0] PEND_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] PEND_ZERO = '0;
  localparam logic [AW-1:0] ZERO_REG = '0;

  logic [CW-1:0] r_pend [NREG];
  logic          r_sb_err;
  logic [31:0]   r_stall_cnt;

  logic [NRD-1:0] w_hz;
  logic           w_inc;
  logic           w_dec;
  logic           w_same;
  logic [CW-1:0]  w_pend_iss;
  logic [CW-1:0]  w_pend_ret;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [AW-1:0] w_a;
    logic [CW-1:0] w_pa;
    logic          w_hit;
    logic          w_rdy;
    logic [DW-1:0] w_fd;
    int            w_nvis;
    logic          w_hidden;
    logic          w_hz_i;
    logic [DW-1:0] w_data;

    assign w_a  = rd_addr[i*AW +: AW];
    assign w_pa = r_pend[w_a];

    // Scan oldest to youngest so the youngest matching stage wins; count every exposing stage
    always_comb begin
      w_hit  = 1'b0;
      w_rdy  = 1'b0;
      w_fd   = '0;
      w_nvis = 0;
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (fwd_we[k] && (fwd_dest[k*AW +: AW] == w_a)) begin
          w_hit  = 1'b1;
          w_rdy  = fwd_rdy[k];
          w_fd   = fwd_data[k*DW +: DW];
          w_nvis = w_nvis + 1;
        end
      end
    end

    // A writer is hidden when more are pending than the pipeline currently exposes
    assign w_hidden = int'(w_pa) > w_nvis;

    // Resolve operand data and this port's hazard; r0 always reads zero without hazard
    always_comb begin
      w_data = rf_rdata[i*DW +: DW];
      w_hz_i = 1'b0;
      if (w_a == ZERO_REG) begin
        w_data = '0;
      end else begin
        if (w_hit) begin
          w_data = w_fd;
          w_hz_i = ~w_rdy;
        end
        if (w_hidden) begin
          w_hz_i = 1'b1;
        end
      end
    end

    assign opnd_data[i*DW +: DW] = w_data;
    assign w_hz[i] = rd_en[i] & w_hz_i;
  end

  assign w_pend_iss = r_pend[iss_dest];
  assign w_pend_ret = r_pend[ret_dest];
  assign w_inc      = iss_fire & iss_we & (iss_dest != ZERO_REG);
  assign w_dec      = ret_fire & (ret_dest != ZERO_REG);
  assign w_same     = w_inc & w_dec & (iss_dest == ret_dest);

  assign sb_full = iss_we & (iss_dest != ZERO_REG) & (w_pend_iss == PEND_MAX)
                 & ~(ret_fire & (ret_dest == iss_dest));
  assign stall   = ds_valid & ((|w_hz) | sb_full);

  // Pending-writer counters: flush or reset wipe all; paired issue/retire on one register cancel
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < NREG; r++) begin
        r_pend[r] <= '0;
      end
    end else begin
      if (w_inc && !w_same && (w_pend_iss != PEND_MAX)) begin
        r_pend[iss_dest] <= w_pend_iss + 1'b1;
      end
      if (w_dec && !w_same && (w_pend_ret != PEND_ZERO)) begin
        r_pend[ret_dest] <= w_pend_ret - 1'b1;
      end
    end
  end

  // Sticky protocol error: retire with nothing pending, or issue while decode is held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb_err <= 1'b0;
    end else if ((!flush && w_dec && !w_same && (w_pend_ret == PEND_ZERO)) || (iss_fire && stall)) begin
      r_sb_err <= 1'b1;
    end
  end

  // Saturating count of cycles where a valid decode instruction is held
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (ds_valid && stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign sb_err    = r_sb_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_fwd_scoreboard.sv
// tb/tb_operand_fwd_scoreboard.sv - scenario bench for operand_fwd_scoreboard
module tb_operand_fwd_scoreboard;

  logic        clk;
  logic        reset;
  logic        ds_valid;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rf_rdata;
  logic [2:0]  fwd_we;
  logic [14:0] fwd_dest;
  logic [2:0]  fwd_rdy;
  logic [95:0] fwd_data;
  logic        iss_we;
  logic [4:0]  iss_dest;
  logic        iss_fire;
  logic        ret_fire;
  logic [4:0]  ret_dest;
  logic        flush;
  logic [63:0] opnd_data;
  logic        stall;
  logic        sb_full;
  logic        sb_err;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] exp_cnt = 0;

  operand_fwd_scoreboard dut (
    .clk(clk), .reset(reset), .ds_valid(ds_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rf_rdata(rf_rdata), .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_rdy(fwd_rdy),
    .fwd_data(fwd_data), .iss_we(iss_we), .iss_dest(iss_dest), .iss_fire(iss_fire),
    .ret_fire(ret_fire), .ret_dest(ret_dest), .flush(flush), .opnd_data(opnd_data),
    .stall(stall), .sb_full(sb_full), .sb_err(sb_err), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    ds_valid = 0; rd_en = 0; rd_addr = 0; rf_rdata = 0;
    fwd_we = 0; fwd_dest = 0; fwd_rdy = 0; fwd_data = 0;
    iss_we = 0; iss_dest = 0; iss_fire = 0; ret_fire = 0; ret_dest = 0; flush = 0;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] d,
                         input logic rdy, input logic [31:0] data);
    fwd_we[k] = we;
    fwd_dest[k*5 +: 5] = d;
    fwd_rdy[k] = rdy;
    fwd_data[k*32 +: 32] = data;
  endtask

  task automatic issue(input logic [4:0] d);
    idle();
    iss_fire = 1; iss_we = 1; iss_dest = d;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    exp_q.push_back(64'h0);
    #1;
    e = exp_q.pop_front();
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL reset_opnd got %h exp %h", opnd_data, e); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_tests++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL reset_sb_full got %b exp 0", sb_full); end
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_sb_err got %b exp 0", sb_err); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_rf_read();
    idle();
    ds_valid = 1; rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
    rf_rdata = {32'h11, 32'h22};
    exp_q.push_back({32'h11, 32'h22});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL rf_read_opnd got %h exp %h", opnd_data, e); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rf_read_stall got %b exp 0", stall); end
    @(negedge clk);
  endtask

  task automatic test_fwd_priority();
    issue(5'd3);
    ds_valid = 1; rd_en = 2'b11; rd_addr = {5'd5, 5'd3}; rf_rdata = {32'h11, 32'h22};
    set_fwd(0, 1, 5'd3, 1, 32'hAB);
    set_fwd(2, 1, 5'd3, 1, 32'hCD);
    exp_q.push_back({32'h11, 32'hAB});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL fwd_youngest got %h exp %h", opnd_data, e); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_youngest_stall got %b exp 0", stall); end
    @(negedge clk);
    set_fwd(0, 0, 5'd0, 0, 32'h0);
    exp_q.push_back({32'h11, 32'hCD});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL fwd_oldest got %h exp %h", opnd_data, e); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fwd_oldest_stall got %b exp 0", stall); end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    idle();
    ds_valid = 1; rd_en = 2'b11; rd_addr = {5'd5, 5'd3}; rf_rdata = {32'h11, 32'h22};
    set_fwd(0, 1, 5'd3, 0, 32'hDEAD);
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got %b exp 1", stall); end
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    set_fwd(0, 1, 5'd3, 1, 32'h55);
    exp_q.push_back({32'h11, 32'h55});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_ready_stall got %b exp 0", stall); end
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL load_ready_opnd got %h exp %h", opnd_data, e); end
    n_tests++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_stall_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    @(negedge clk);
    idle();
    ret_fire = 1; ret_dest = 5'd3;
    @(negedge clk);
  endtask

  task automatic test_divider();
    issue(5'd7);
    ds_valid = 1; rd_en = 2'b00; rd_addr = {5'd0, 5'd7};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL div_unused_port_stall got %b exp 0", stall); end
    @(negedge clk);
    rd_en = 2'b01;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL div_hidden_stall got %b exp 1", stall); end
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    idle();
    ret_fire = 1; ret_dest = 5'd7;
    @(negedge clk);
    idle();
    ds_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd7}; rf_rdata = {32'h0, 32'h77};
    exp_q.push_back({32'h0, 32'h77});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL div_retired_stall got %b exp 0", stall); end
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL div_retired_opnd got %h exp %h", opnd_data, e); end
    n_tests++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL div_stall_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 3; n++) issue(5'd4);
    ds_valid = 1; iss_we = 1; iss_dest = 5'd4;
    #1;
    n_tests++; if (sb_full !== 1'b1) begin n_fail++; $display("FAIL sat_sb_full got %b exp 1", sb_full); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall got %b exp 1", stall); end
    @(negedge clk);
    exp_cnt = exp_cnt + 1;
    ret_fire = 1; ret_dest = 5'd4;
    #1;
    n_tests++; if (sb_full !== 1'b0) begin n_fail++; $display("FAIL sat_retire_sb_full got %b exp 0", sb_full); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_retire_stall got %b exp 0", stall); end
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL sat_sb_err got %b exp 0", sb_err); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    issue(5'd2);
    issue(5'd2);
    flush = 1; iss_fire = 1; iss_we = 1; iss_dest = 5'd2;
    @(negedge clk);
    idle();
    ds_valid = 1; rd_en = 2'b11; rd_addr = {5'd4, 5'd2};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall); end
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL flush_sb_err got %b exp 0", sb_err); end
    @(negedge clk);
    idle();
    ret_fire = 1; ret_dest = 5'd2;
    @(negedge clk);
    idle();
    #1;
    n_tests++; if (sb_err !== 1'b1) begin n_fail++; $display("FAIL underflow_sb_err got %b exp 1", sb_err); end
    ds_valid = 1; rd_en = 2'b11; rd_addr = {5'd4, 5'd0}; rf_rdata = {32'h44, 32'h33};
    set_fwd(0, 1, 5'd0, 1, 32'h99);
    exp_q.push_back({32'h44, 32'h0});
    #1;
    e = exp_q.pop_front();
    n_tests++; if (opnd_data !== e) begin n_fail++; $display("FAIL r0_opnd got %h exp %h", opnd_data, e); end
    n_tests++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_stall_cnt got %0d exp %0d", stall_cnt, exp_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    issue(5'd9);
    reset = 1; iss_fire = 1; iss_we = 1; iss_dest = 5'd9;
    @(negedge clk);
    reset = 0;
    idle();
    ds_valid = 1; rd_en = 2'b01; rd_addr = {5'd0, 5'd9};
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall got %b exp 0", stall); end
    n_tests++; if (sb_err !== 1'b0) begin n_fail++; $display("FAIL midreset_sb_err got %b exp 0", sb_err); end
    n_tests++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL midreset_stall_cnt got %0d exp 0", stall_cnt); end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_rf_read();
    test_fwd_priority();
    test_load_use();
    test_divider();
    test_saturation();
    test_flush();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
